// File: rtl/ni_pkg.sv
// Shared types and defaults for the local-port network interface.
package ni_pkg;

  localparam int unsigned FLIT_W = 32;
  localparam int unsigned ADDR_W = 8;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    T_IDLE,
    T_SEND
  } tx_state_t;

  // Destination node address carried in the top bits of a flit
  function automatic logic [ADDR_W-1:0] get_dest(input flit_t f);
    return f[FLIT_W-1 -: ADDR_W];
  endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO without
// a same-cycle pop is dropped and flagged on ovf_c.
module ni_rx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       ovf_c
);
  import ni_pkg::*;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign ovf_c   = push_i & full_o & ~do_pop;

  // Pointer, occupancy and storage update
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = next_ptr(wr_q);
    end
    if (do_pop) rd_d = next_ptr(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Control state, cleared on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ni_local_port.sv
// PE-side network interface for the router local port.
// TX: credit-gated, one-cycle-latency flit register. RX: buffered FIFO that
// returns one credit per consumed flit.
// Optional: define NI_DEST_CHECK_EN to reject RX flits not addressed to
// myaddr_i (adds misroute_o).
module ni_local_port #(
  parameter int unsigned FLIT_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TX_CREDITS = 4,
  parameter int unsigned RX_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] myaddr_i,
  input  logic [FLIT_W-1:0] pe_tx_data_i,
  input  logic              pe_tx_valid_i,
  output logic              pe_tx_ready_o,
  output logic [FLIT_W-1:0] local_o,
  output logic              valid_l_o,
  input  logic              credit_l_i,
  input  logic [FLIT_W-1:0] local_i,
  input  logic              valid_l_i,
  output logic              credit_l_o,
  output logic [FLIT_W-1:0] pe_rx_data_o,
  output logic              pe_rx_valid_o,
  input  logic              pe_rx_ready_i,
  output logic [1:0]        err_o
`ifdef NI_DEST_CHECK_EN
  ,
  output logic              misroute_o
`endif
);
  import ni_pkg::*;

  localparam int unsigned CW  = $clog2(TX_CREDITS + 1);
  localparam int unsigned PCW = $clog2(RX_DEPTH + 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic [FLIT_W-1:0] local_q, local_d;
  logic              cred_ovf_q, cred_ovf_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic              credit_q, credit_d;
  logic              xfer_c, accept_c, pop_c, ovf_c, rx_empty_c, dest_ok_c;
  logic              rx_full_unused;
  logic [PCW-1:0]    rx_count_unused;

  assign pe_tx_ready_o = (cred_q != '0);
  assign xfer_c        = pe_tx_valid_i & pe_tx_ready_o;
  assign local_o       = local_q;
  assign valid_l_o     = (state_q == T_SEND);
  assign credit_l_o    = credit_q;
  assign err_o         = {rx_ovf_q, cred_ovf_q};
  assign pe_rx_valid_o = ~rx_empty_c;
  assign pop_c         = pe_rx_valid_o & pe_rx_ready_i;
  assign accept_c      = valid_l_i & dest_ok_c;

  // TX FSM: T_SEND marks the cycle a registered flit is on local_o
  always_comb begin
    state_d = state_q;
    local_d = local_q;
    case (state_q)
      T_IDLE:  if (xfer_c) state_d = T_SEND;
      T_SEND:  if (!xfer_c) state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
    if (xfer_c) local_d = pe_tx_data_i;
  end

  // TX credit counter; a return into a full counter saturates and is flagged
  always_comb begin
    cred_d     = cred_q;
    cred_ovf_d = cred_ovf_q;
    case ({credit_l_i, xfer_c})
      2'b10: begin
        if (cred_q == CW'(TX_CREDITS)) cred_ovf_d = 1'b1;
        else                           cred_d     = cred_q + CW'(1);
      end
      2'b01:   cred_d = cred_q - CW'(1);
      default: cred_d = cred_q;
    endcase
  end

  ni_rx_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept_c),
    .data_i  (local_i),
    .pop_i   (pop_c),
    .head_o  (pe_rx_data_o),
    .full_o  (rx_full_unused),
    .empty_o (rx_empty_c),
    .count_o (rx_count_unused),
    .ovf_c   (ovf_c)
  );

  assign rx_ovf_d = rx_ovf_q | ovf_c;

`ifdef NI_DEST_CHECK_EN
  // Rejected flits still return their credit. Owed credits beyond the one
  // sent this cycle wait in pend_q; the router cannot have more than
  // RX_DEPTH outstanding, so pend_q never overflows.
  logic           mis_c, mis_q, mis_d;
  logic [PCW-1:0] pend_q, pend_d;
  logic [PCW:0]   owed_c;

  assign dest_ok_c  = (local_i[FLIT_W-1 -: ADDR_W] == myaddr_i);
  assign mis_c      = valid_l_i & ~dest_ok_c;
  assign misroute_o = mis_q;

  // Credit return merging pops, misroutes and deferred credits
  always_comb begin
    mis_d    = mis_q | mis_c;
    owed_c   = (PCW+1)'(pend_q) + (PCW+1)'(pop_c) + (PCW+1)'(mis_c);
    credit_d = (owed_c != '0);
    pend_d   = PCW'(owed_c - (PCW+1)'(credit_d));
  end

  // Misroute and deferred-credit state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      mis_q  <= mis_d;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_addr;

  assign dest_ok_c   = 1'b1;
  assign unused_addr = ^myaddr_i;

  // One credit per popped flit
  always_comb begin
    credit_d = pop_c;
  end
`endif

  // Main state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= T_IDLE;
      cred_q     <= CW'(TX_CREDITS);
      local_q    <= '0;
      cred_ovf_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      credit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cred_q     <= cred_d;
      local_q    <= local_d;
      cred_ovf_q <= cred_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      credit_q   <= credit_d;
    end
  end

endmodule

// File: tb/tb_ni_local_port.sv
// Scoreboard bench for ni_local_port: TX flits and owed credits are queued
// when stimulus is driven and retired when the DUT produces them.
// Covers the NI_DEST_CHECK_EN build when that macro is defined.
module tb_ni_local_port;

  localparam int unsigned FLIT_W     = 32;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned TX_CREDITS = 4;
  localparam int unsigned RX_DEPTH   = 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] myaddr_i;
  logic [FLIT_W-1:0] pe_tx_data_i;
  logic              pe_tx_valid_i;
  logic              pe_tx_ready_o;
  logic [FLIT_W-1:0] local_o;
  logic              valid_l_o;
  logic              credit_l_i;
  logic [FLIT_W-1:0] local_i;
  logic              valid_l_i;
  logic              credit_l_o;
  logic [FLIT_W-1:0] pe_rx_data_o;
  logic              pe_rx_valid_o;
  logic              pe_rx_ready_i;
  logic [1:0]        err_o;
`ifdef NI_DEST_CHECK_EN
  logic              misroute_o;
`endif

  ni_local_port #(
    .FLIT_W     (FLIT_W),
    .ADDR_W     (ADDR_W),
    .TX_CREDITS (TX_CREDITS),
    .RX_DEPTH   (RX_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .myaddr_i      (myaddr_i),
    .pe_tx_data_i  (pe_tx_data_i),
    .pe_tx_valid_i (pe_tx_valid_i),
    .pe_tx_ready_o (pe_tx_ready_o),
    .local_o       (local_o),
    .valid_l_o     (valid_l_o),
    .credit_l_i    (credit_l_i),
    .local_i       (local_i),
    .valid_l_i     (valid_l_i),
    .credit_l_o    (credit_l_o),
    .pe_rx_data_o  (pe_rx_data_o),
    .pe_rx_valid_o (pe_rx_valid_o),
    .pe_rx_ready_i (pe_rx_ready_i),
    .err_o         (err_o)
`ifdef NI_DEST_CHECK_EN
    ,
    .misroute_o    (misroute_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fails;
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  int          m_cred;
  logic [1:0]  m_err;
  logic        m_mis;
  int          cr_pend;
  bit          mon_en;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Retire expected TX flits and owed credits just after each active edge
  always @(posedge clk) begin
    logic [31:0] exp_flit;
    #1;
    if (mon_en) begin
      check_eq("tx_valid", 32'(valid_l_o), 32'(txq.size() != 0));
      if (txq.size() != 0) begin
        exp_flit = txq.pop_front();
        if (valid_l_o) check_eq("tx_data", local_o, exp_flit);
      end
      check_eq("credit_out", 32'(credit_l_o), 32'(cr_pend != 0));
      if (cr_pend > 0) cr_pend--;
    end
  end

  // One clock of stimulus: check pre-edge outputs, drive inputs, update model
  task automatic cycle(input bit tx_v, input logic [31:0] tx_d, input bit cr,
                       input bit rx_v, input logic [31:0] rx_d, input bit rx_rdy);
    bit xfer;
    bit pop;
    bit store;
    int occ;
    @(negedge clk);
    check_eq("tx_ready", 32'(pe_tx_ready_o), 32'(m_cred != 0));
    check_eq("rx_valid", 32'(pe_rx_valid_o), 32'(rxq.size() != 0));
    if (rxq.size() != 0) check_eq("rx_head", pe_rx_data_o, rxq[0]);
    check_eq("err", 32'(err_o), 32'(m_err));
`ifdef NI_DEST_CHECK_EN
    check_eq("misroute", 32'(misroute_o), 32'(m_mis));
`endif
    xfer = tx_v && (m_cred != 0);
    pop  = rx_rdy && (rxq.size() != 0);
    pe_tx_valid_i = tx_v;
    pe_tx_data_i  = tx_d;
    credit_l_i    = cr;
    valid_l_i     = rx_v;
    local_i       = rx_d;
    pe_rx_ready_i = rx_rdy;
    if (xfer) txq.push_back(tx_d);
    if (cr && !xfer) begin
      if (m_cred == int'(TX_CREDITS)) m_err[0] = 1'b1;
      else                            m_cred++;
    end else if (xfer && !cr) begin
      m_cred--;
    end
    occ = rxq.size();
    if (pop) begin
      rxq.delete(0);
      cr_pend++;
    end
    store = rx_v;
`ifdef NI_DEST_CHECK_EN
    if (rx_v && (rx_d[31:24] != myaddr_i)) begin
      store = 1'b0;
      m_mis = 1'b1;
      cr_pend++;
    end
`endif
    if (store) begin
      if (occ < int'(RX_DEPTH) || pop) rxq.push_back(rx_d);
      else                             m_err[1] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    n_checks = 0;
    n_fails  = 0;
    m_cred   = TX_CREDITS;
    m_err    = 2'b00;
    m_mis    = 1'b0;
    cr_pend  = 0;
    mon_en   = 1'b0;
    rst           = 1'b0;
    myaddr_i      = 8'h12;
    pe_tx_data_i  = '0;
    pe_tx_valid_i = 1'b0;
    credit_l_i    = 1'b0;
    local_i       = '0;
    valid_l_i     = 1'b0;
    pe_rx_ready_i = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_valid_l", 32'(valid_l_o), 32'd0);
    check_eq("rst_local", local_o, 32'd0);
    check_eq("rst_credit_l", 32'(credit_l_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_rx_valid", 32'(pe_rx_valid_o), 32'd0);
    check_eq("rst_tx_ready", 32'(pe_tx_ready_o), 32'd1);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Four back-to-back PE flits exhaust the credits; the fifth is refused
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, '0, 1'b0);
    idle(1);

    // Credit return at zero enables exactly one more flit
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h2000_0001, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h2000_0002, 1'b0, 1'b0, '0, 1'b0);

    // Transfer with same-cycle credit at 2 keeps 2; overflow at 4 is sticky
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h3000_0001, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3000_0002 + 32'(i), 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);

    // Fill the RX FIFO, then overflow it
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1, 32'h1200_00A0 + 32'(i), 1'b0);
    idle(1);

    // Drain in order; each pop returns one credit the following cycle
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 32'h1200_00B0 + 32'(i), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h1200_00B4, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);

`ifdef NI_DEST_CHECK_EN
    // Misaddressed flit is dropped, flagged and its credit returned
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h1300_0055, 1'b0);
    idle(3);
    // Misroute credit coinciding with a pop credit
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h1200_00C0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h1300_0066, 1'b1);
    idle(4);
`endif

    // Random mixed traffic
    for (int i = 0; i < 80; i++) begin
      d = $urandom;
`ifdef NI_DEST_CHECK_EN
      if ($urandom_range(3) != 0) d[31:24] = myaddr_i;
`endif
      cycle(1'($urandom_range(1)), $urandom, ($urandom_range(3) == 0),
            1'($urandom_range(1)), d, ($urandom_range(2) != 0));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(4);

    check_eq("tx_drained", 32'(txq.size()), 32'd0);
    check_eq("credits_drained", 32'(cr_pend), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
